// File: rtl/fc_result_argmax.sv
// Per-sample argmax over the fc_3 logit stream; a result is visible 1 clk after the last logit of a sample.
// Results drain from a FWFT FIFO over valid/ready; when full without a pop they are dropped (sticky overflow). ARGMAX_SCORE_EN stores the score.
module fc_result_argmax #(
   parameter int DATA_W      = 36,
   parameter int NUM_CLASSES = 2,
   parameter int NUM_SAMPLES = 42,
   parameter int FIFO_DEPTH  = 8,
   localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic                     logit_en_i,
   input  logic signed [DATA_W-1:0] logit_i,
   output logic                     result_valid_o,
   input  logic                     result_ready_i,
   output logic [7:0]               result_idx_o,
   output logic [CLS_W-1:0]         result_class_o,
   output logic signed [DATA_W-1:0] result_score_o,
   output logic [CNT_W-1:0]         fifo_count_o,
   output logic                     overflow_o,
   output logic                     all_done_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(NUM_CLASSES - 1);
   localparam logic [7:0]       LAST_SMP = 8'(NUM_SAMPLES - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

   state_t                   r_state, w_state_nxt;
   logic [CLS_W-1:0]         r_cls_cnt;
   logic [7:0]               r_sample_cnt;
   logic signed [DATA_W-1:0] r_best;
   logic [CLS_W-1:0]         r_best_cls;
   logic [7:0]               r_mem_idx [FIFO_DEPTH];
   logic [CLS_W-1:0]         r_mem_cls [FIFO_DEPTH];
`ifdef ARGMAX_SCORE_EN
   logic signed [DATA_W-1:0] r_mem_score [FIFO_DEPTH];
`endif
   logic [PTR_W-1:0]         r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]         r_count;
   logic                     r_overflow, r_all_done;

   logic                     w_take, w_last, w_gt, w_push, w_full, w_pop, w_wr;
   logic signed [DATA_W-1:0] w_best_nxt;
   logic [CLS_W-1:0]         w_cls_nxt;

   // The last logit's comparison is folded in here so the push carries the final winner.
   always_comb begin
      w_take     = logit_en_i && (r_state == S_COLLECT) && !start_i;
      w_last     = (r_cls_cnt == LAST_CLS);
      w_gt       = logit_i > r_best;
      w_best_nxt = r_best;
      w_cls_nxt  = r_best_cls;
      if ((r_cls_cnt == '0) || w_gt) begin
         w_best_nxt = logit_i;
         w_cls_nxt  = r_cls_cnt;
      end
      w_push = w_take && w_last;
      w_full = (r_count == FULL_CNT);
      w_pop  = (r_count != '0) && result_ready_i;
      w_wr   = w_push && (!w_full || w_pop);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (start_i) w_state_nxt = S_COLLECT;
         S_COLLECT: begin
            if (start_i)                                 w_state_nxt = S_COLLECT;
            else if (w_push && (r_sample_cnt == LAST_SMP)) w_state_nxt = S_DONE;
         end
         S_DONE:    if (start_i) w_state_nxt = S_COLLECT;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_cls_cnt    <= '0;
         r_sample_cnt <= '0;
         r_best       <= '0;
         r_best_cls   <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_overflow   <= 1'b0;
         r_all_done   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (start_i) begin
            r_cls_cnt    <= '0;
            r_sample_cnt <= '0;
            r_best       <= '0;
            r_best_cls   <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_all_done   <= 1'b0;
         end else begin
            if (w_take) begin
               r_cls_cnt  <= w_last ? '0 : r_cls_cnt + 1'b1;
               r_best     <= w_best_nxt;
               r_best_cls <= w_cls_nxt;
            end
            if (w_push) begin
               r_sample_cnt <= r_sample_cnt + 8'd1;
               if (r_sample_cnt == LAST_SMP) r_all_done <= 1'b1;
               if (!w_wr)                    r_overflow <= 1'b1;
            end
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_wr) begin
         r_mem_idx[r_wr_ptr]   <= r_sample_cnt;
         r_mem_cls[r_wr_ptr]   <= w_cls_nxt;
`ifdef ARGMAX_SCORE_EN
         r_mem_score[r_wr_ptr] <= w_best_nxt;
`endif
      end
   end

   // Head fields are masked while empty so stale storage never reaches the outputs.
   assign result_valid_o = (r_count != '0);
   assign result_idx_o   = result_valid_o ? r_mem_idx[r_rd_ptr] : '0;
   assign result_class_o = result_valid_o ? r_mem_cls[r_rd_ptr] : '0;
`ifdef ARGMAX_SCORE_EN
   assign result_score_o = result_valid_o ? r_mem_score[r_rd_ptr] : '0;
`else
   assign result_score_o = '0;
`endif
   assign fifo_count_o   = r_count;
   assign overflow_o     = r_overflow;
   assign all_done_o     = r_all_done;

endmodule

// File: tb/tb_fc_result_argmax.sv
// Randomized scoreboard bench for fc_result_argmax: stimulus queues expected results, a negedge monitor checks each handshake.
module tb_fc_result_argmax;
   localparam int DATA_W      = 36;
   localparam int NUM_CLASSES = 2;
   localparam int NUM_SAMPLES = 42;
   localparam int FIFO_DEPTH  = 8;
   localparam int CLS_W       = 1;
   localparam int CNT_W       = 4;

   typedef struct {
      logic [7:0]               idx;
      logic [CLS_W-1:0]         cls;
      logic signed [DATA_W-1:0] score;
   } res_t;

   logic                     clk_i = 1'b0;
   logic                     rst_i, start_i, logit_en_i, result_ready_i;
   logic signed [DATA_W-1:0] logit_i;
   logic                     result_valid_o, overflow_o, all_done_o;
   logic [7:0]               result_idx_o;
   logic [CLS_W-1:0]         result_class_o;
   logic signed [DATA_W-1:0] result_score_o;
   logic [CNT_W-1:0]         fifo_count_o;

   res_t exp_q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   bit   m_collect = 1'b0, m_ovf = 1'b0, m_done = 1'b0;
   int   m_sidx = 0;
   bit   rnd_rdy = 1'b0, rdy_on_last = 1'b0;

   fc_result_argmax #(
      .DATA_W(DATA_W), .NUM_CLASSES(NUM_CLASSES), .NUM_SAMPLES(NUM_SAMPLES), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .logit_en_i(logit_en_i), .logit_i(logit_i),
      .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_idx_o(result_idx_o),
      .result_class_o(result_class_o), .result_score_o(result_score_o), .fifo_count_o(fifo_count_o),
      .overflow_o(overflow_o), .all_done_o(all_done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic signed [DATA_W-1:0] rnd_logit();
      logic [63:0] v;
      v = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) return DATA_W'($signed($urandom_range(0, 8)) - 4);
      return v[DATA_W-1:0];
   endfunction

   // Reference: argmax with strictly-greater replacement, FIFO acceptance from queue occupancy.
   task automatic model_push(input int cls, input logic signed [DATA_W-1:0] sc);
      res_t r;
      r.idx   = 8'(m_sidx);
      r.cls   = CLS_W'(cls);
      r.score = sc;
`ifndef ARGMAX_SCORE_EN
      r.score = '0;
`endif
      if (exp_q.size() < FIFO_DEPTH || result_ready_i) exp_q.push_back(r);
      else m_ovf = 1'b1;
      m_sidx++;
      if (m_sidx == NUM_SAMPLES) begin
         m_collect = 1'b0;
         m_done    = 1'b1;
      end
   endtask

   task automatic send_pair(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b);
      logic signed [DATA_W-1:0] lg [NUM_CLASSES];
      int best;
      lg[0] = a;
      lg[1] = b;
      best  = 0;
      for (int i = 1; i < NUM_CLASSES; i++) if (lg[i] > lg[best]) best = i;
      for (int i = 0; i < NUM_CLASSES; i++) begin
         if (rnd_rdy)     result_ready_i = 1'($urandom_range(0, 1));
         if (rdy_on_last) result_ready_i = (i == NUM_CLASSES - 1);
         logit_en_i = 1'b1;
         logit_i    = lg[i];
         if (i == NUM_CLASSES - 1 && m_collect) model_push(best, lg[best]);
         tick();
      end
      logit_en_i = 1'b0;
      if (rdy_on_last) result_ready_i = 1'b0;
   endtask

   task automatic send_rnd();
      logic signed [DATA_W-1:0] a, b;
      a = rnd_logit();
      b = ($urandom_range(0, 3) == 0) ? a : rnd_logit();
      send_pair(a, b);
   endtask

   task automatic start_run();
      start_i = 1'b1;
      exp_q.delete();
      m_sidx = 0; m_ovf = 1'b0; m_done = 1'b0; m_collect = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      exp_q.delete();
      m_sidx = 0; m_ovf = 1'b0; m_done = 1'b0; m_collect = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic check_state(input string name);
      chk({name, "_count"},    64'(fifo_count_o), 64'(exp_q.size()));
      chk({name, "_overflow"}, 64'(overflow_o),   64'(m_ovf));
      chk({name, "_all_done"}, 64'(all_done_o),   64'(m_done));
   endtask

   task automatic check_zero(input string name);
      chk({name, "_valid"}, 64'(result_valid_o), 64'(0));
      chk({name, "_idx"},   64'(result_idx_o),   64'(0));
      chk({name, "_cls"},   64'(result_class_o), 64'(0));
      chk({name, "_score"}, 64'(result_score_o), 64'(0));
      chk({name, "_count"}, 64'(fifo_count_o),   64'(0));
      chk({name, "_ovf"},   64'(overflow_o),     64'(0));
      chk({name, "_done"},  64'(all_done_o),     64'(0));
   endtask

   task automatic drain(input string name);
      result_ready_i = 1'b1;
      for (int k = 0; k < 64 && exp_q.size() > 0; k++) tick();
      chk({name, "_drained"},   64'(exp_q.size()),  64'(0));
      chk({name, "_count_end"}, 64'(fifo_count_o), 64'(0));
      result_ready_i = 1'b0;
   endtask

   // Monitor: every accepted head must match the oldest expected result.
   initial begin
      res_t e;
      forever begin
         @(negedge clk_i);
         if (!rst_i && !start_i && result_valid_o && result_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("mon_unexpected_result", 64'(1), 64'(0));
            end else begin
               e = exp_q.pop_front();
               chk("mon_idx",   64'(result_idx_o),   64'(e.idx));
               chk("mon_class", 64'(result_class_o), 64'(e.cls));
               chk("mon_score", 64'(result_score_o), 64'(e.score));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
      $fatal(1);
   end

   initial begin
      logic signed [DATA_W-1:0] minv, maxv;
      minv = {1'b1, {(DATA_W-1){1'b0}}};
      maxv = {1'b0, {(DATA_W-1){1'b1}}};
      rst_i = 1'b0; start_i = 1'b0; logit_en_i = 1'b0; logit_i = '0; result_ready_i = 1'b0;
      do_reset();
      check_zero("reset");

      // Logits before any start are ignored.
      send_pair(3, 4);
      tick();
      check_state("idle_ignore");

      // Basic results and one-cycle latency.
      start_run();
      result_ready_i = 1'b1;
      send_pair(5, -3);
      chk("t1_latency_a", 64'(result_valid_o), 64'(1));
      send_pair(-7, 2);
      chk("t1_latency_b", 64'(result_valid_o), 64'(1));
      // Ties and extreme signed values.
      send_pair(-1, -1);
      send_pair(minv, maxv);
      drain("t2");

      // Fill without ready: ninth sample is dropped.
      start_run();
      result_ready_i = 1'b0;
      for (int s = 0; s < 9; s++) send_rnd();
      chk("t3_count_full", 64'(fifo_count_o), 64'(8));
      chk("t3_overflow",   64'(overflow_o),   64'(1));
      check_state("t3");
      drain("t3");

      // Full FIFO with a pop coinciding with the push.
      start_run();
      for (int s = 0; s < 8; s++) send_rnd();
      rdy_on_last = 1'b1;
      send_rnd();
      rdy_on_last = 1'b0;
      chk("t4_count_full", 64'(fifo_count_o), 64'(8));
      chk("t4_no_overflow", 64'(overflow_o),  64'(0));
      check_state("t4");
      drain("t4");

      // Full run with random backpressure, then post-run logits ignored.
      start_run();
      rnd_rdy = 1'b1;
      for (int s = 0; s < NUM_SAMPLES; s++) send_rnd();
      rnd_rdy = 1'b0;
      result_ready_i = 1'b0;
      chk("t5_all_done", 64'(all_done_o), 64'(1));
      check_state("t5_run");
      send_rnd();
      tick();
      check_state("t5_after_extra");
      drain("t5");
      start_run();
      chk("t5_done_cleared", 64'(all_done_o), 64'(0));
      result_ready_i = 1'b1;
      send_rnd();
      drain("t5_restart");

      // Reset mid-sample with queued results.
      start_run();
      result_ready_i = 1'b0;
      send_rnd();
      send_rnd();
      logit_en_i = 1'b1;
      logit_i    = rnd_logit();
      tick();
      logit_en_i = 1'b0;
      do_reset();
      check_zero("t6_reset");
      start_run();
      result_ready_i = 1'b1;
      send_pair(4, 9);
      drain("t6");
      check_state("final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
